// File: rtl/ptp_pkg.sv
// ---------------------------------------------------------------------------
// ptp_pkg
//   Shared IO-bus definitions for the paper tape devices (punch and reader).
//   Contents:
//     PTP_DEV_CODE  ios[3:9] select code of the punch (device 100 octal).
//                   The reader (device 104) decodes as 7'b001_000_1.
//     CONI_*        bit positions (IO bus [0:35] numbering) of the
//                   status word fields.
//     ptp_state_e   punch sequencer states.
//     pia_decode    3-bit PI assignment -> one-hot request on [1:7].
// ---------------------------------------------------------------------------
package ptp_pkg;

   localparam logic [6:0] PTP_DEV_CODE = 7'b001_000_0;

   localparam int CONI_BINARY = 30;
   localparam int CONI_BUSY   = 31;
   localparam int CONI_FLAG   = 32;
   localparam int CONI_PIA_LO = 33;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } ptp_state_e;

   // PIA 0 means "no interrupt level"; levels 1..7 map to request lines 1..7.
   function automatic logic [1:7] pia_decode(input logic [2:0] pia);
      logic [1:7] req;
      req = '0;
      for (int i = 1; i <= 7; i++) begin
         req[i] = (pia == 3'(i));
      end
      return req;
   endfunction

endpackage

// File: rtl/ptp_iob_edge.sv
// ---------------------------------------------------------------------------
// ptp_iob_edge
//   Converts a multi-cycle IO bus level pulse into a one-clock strobe on its
//   rising edge. The strobe is combinational (level & ~previous level), so
//   the action happens on the first clock edge that sees the level high.
//   Ports:
//     clk     system clock
//     rst     asynchronous active-high reset
//     level   bus pulse (level, may last many clocks)
//     strobe  high during the first clock the level is seen high
// ---------------------------------------------------------------------------
module ptp_iob_edge (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic strobe
);

   logic prev_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_reg <= 1'b0;
      end else begin
         prev_reg <= level;
      end
   end

   assign strobe = level & ~prev_reg;

endmodule

// File: rtl/ptp.sv
// ---------------------------------------------------------------------------
// ptp
//   PDP-6 paper tape punch on the IO bus. The CPU DATAOs a frame into the
//   punch buffer, the front end fetches it through the slave read port, and
//   once the punch delay expires the done flag raises a PI request.
//   Ports:
//     clk, reset               clock, asynchronous active-high reset
//     iobus_iob_poweron        low = power off, behaves as a clear
//     iobus_iob_reset          synchronous clear of flags, PIA, buffer, FSM
//     iobus_datao_*/cono_*     bus pulses (levels, edge detected here)
//     iobus_iob_fm_datai       DATAI strobe (punch returns zero)
//     iobus_iob_fm_status      CONI strobe
//     iobus_ios[3:9]           device select
//     iobus_iob_in[0:35]       bus data in
//     iobus_pi_req[1:7]        PI request, one-hot on PIA level
//     iobus_iob_out[0:35]      bus data out (CONI status word)
//     key_tape_feed            punch blank leader frames while held
//     s_read / s_readdata      front-end read port {23'b0, valid, frame}
//     fe_data_rq               frame waiting for the front end
// ---------------------------------------------------------------------------
module ptp
   import ptp_pkg::*;
#(
   parameter logic [6:0] DEV_CODE    = PTP_DEV_CODE,
   parameter int         PUNCH_DELAY = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iobus_iob_poweron,
   input  logic        iobus_iob_reset,
   input  logic        iobus_datao_clear,
   input  logic        iobus_datao_set,
   input  logic        iobus_cono_clear,
   input  logic        iobus_cono_set,
   input  logic        iobus_iob_fm_datai,
   input  logic        iobus_iob_fm_status,
   input  logic [3:9]  iobus_ios,
   input  logic [0:35] iobus_iob_in,
   output logic [1:7]  iobus_pi_req,
   output logic [0:35] iobus_iob_out,
   input  logic        key_tape_feed,
   input  logic        s_read,
   output logic [31:0] s_readdata,
   output logic        fe_data_rq
);

   localparam int            CW       = (PUNCH_DELAY > 1) ? $clog2(PUNCH_DELAY) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PUNCH_DELAY - 1);

   ptp_state_e    state_reg, state_next;
   logic [CW-1:0] cnt_reg;
   logic [2:0]    pia_reg;
   logic          flag_reg, busy_reg, binary_reg;
   logic [7:0]    buf_reg;
   logic          feed_reg;   // current frame is a tape-feed blank
   logic          pend_reg;   // DATAO arrived while a frame was finishing

   logic       sel, clr;
   logic [3:0] lvl, stb;
   logic       datao_clr, datao_set, cono_clr, cono_set;
   logic       feed_start;
   logic [7:0] frame;
   logic       unused_bits;

   assign sel = (iobus_ios == DEV_CODE);
   // Power-off and IO reset both clear the device on the next clock.
   assign clr = ~iobus_iob_poweron | iobus_iob_reset;

   assign lvl = {iobus_cono_set, iobus_cono_clear, iobus_datao_set, iobus_datao_clear};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_edge
         ptp_iob_edge u_edge (
            .clk    (clk),
            .rst    (reset),
            .level  (lvl[gi]),
            .strobe (stb[gi])
         );
      end
   endgenerate

   assign datao_clr = stb[0] & sel & iobus_iob_poweron;
   assign datao_set = stb[1] & sel & iobus_iob_poweron;
   assign cono_clr  = stb[2] & sel & iobus_iob_poweron;
   assign cono_set  = stb[3] & sel & iobus_iob_poweron;

   // Leader feed only starts from an idle, non-busy punch with no DATAO pending.
   assign feed_start = (state_reg == ST_IDLE) & ~busy_reg & key_tape_feed
                       & ~datao_set & ~pend_reg;

   assign frame = feed_reg   ? 8'd0 :
                  binary_reg ? {2'b10, buf_reg[5:0]} : buf_reg;

   assign unused_bits = &{1'b0, iobus_iob_in[0:27]};

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (datao_set || pend_reg || feed_start) state_next = ST_REQ;
         ST_REQ:  if (s_read) state_next = ST_WAIT;
         ST_WAIT: if (cnt_reg == CNT_LAST) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      if (clr) begin
         state_next = ST_IDLE;
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      fe_data_rq = iobus_iob_poweron & (state_reg == ST_REQ);
      s_readdata = '0;
      if (s_read && iobus_iob_poweron && state_reg == ST_REQ) begin
         s_readdata = {23'd0, 1'b1, frame};
      end
   end

   // ---------------- punch delay counter ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (clr || state_reg != ST_WAIT || cnt_reg == CNT_LAST) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   // ---------------- flags, PIA, buffer ----------------
   // Statement order sets priority: frame completion first, then CONO/DATAO
   // clears, then sets, so a clear in the DONE clock wins over the flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pia_reg    <= '0;
         flag_reg   <= 1'b0;
         busy_reg   <= 1'b0;
         binary_reg <= 1'b0;
         buf_reg    <= '0;
         feed_reg   <= 1'b0;
         pend_reg   <= 1'b0;
      end else if (clr) begin
         pia_reg    <= '0;
         flag_reg   <= 1'b0;
         busy_reg   <= 1'b0;
         binary_reg <= 1'b0;
         buf_reg    <= '0;
         feed_reg   <= 1'b0;
         pend_reg   <= 1'b0;
      end else begin
         if (state_reg == ST_IDLE) begin
            feed_reg <= feed_start;
            pend_reg <= 1'b0;
         end else if (datao_set && (state_reg == ST_DONE || feed_reg)) begin
            // A frame is ending (or is only leader): start the new one after it.
            pend_reg <= 1'b1;
         end

         if (state_reg == ST_DONE && !feed_reg) begin
            busy_reg <= 1'b0;
            flag_reg <= 1'b1;
         end

         if (cono_clr) begin
            pia_reg    <= '0;
            flag_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            binary_reg <= 1'b0;
         end
         if (datao_clr) begin
            buf_reg  <= '0;
            flag_reg <= 1'b0;
         end
         if (cono_set) begin
            pia_reg    <= pia_reg | iobus_iob_in[CONI_PIA_LO:CONI_PIA_LO+2];
            flag_reg   <= flag_reg | iobus_iob_in[CONI_FLAG];
            busy_reg   <= busy_reg | iobus_iob_in[CONI_BUSY];
            binary_reg <= binary_reg | iobus_iob_in[CONI_BINARY];
         end
         if (datao_set) begin
            buf_reg  <= buf_reg | iobus_iob_in[28:35];
            busy_reg <= 1'b1;
         end
      end
   end

   // ---------------- bus outputs ----------------
   always_comb begin
      iobus_pi_req = '0;
      if (iobus_iob_poweron && flag_reg) begin
         iobus_pi_req = pia_decode(pia_reg);
      end

      iobus_iob_out = '0;
      if (iobus_iob_poweron && sel && iobus_iob_fm_status && !iobus_iob_fm_datai) begin
         iobus_iob_out[CONI_BINARY]                  = binary_reg;
         iobus_iob_out[CONI_BUSY]                    = busy_reg;
         iobus_iob_out[CONI_FLAG]                    = flag_reg;
         iobus_iob_out[CONI_PIA_LO:CONI_PIA_LO+2]    = pia_reg;
      end
   end

endmodule

// File: tb/tb_ptp.sv
// ---------------------------------------------------------------------------
// tb_ptp
//   Directed bench for the paper tape punch. Front-end reads push their
//   expected readdata into a queue; a monitor on the falling clock edge pops
//   and compares whenever s_read is presented. Status (CONI, PI request,
//   fe_data_rq) is checked directly from the stimulus thread.
// ---------------------------------------------------------------------------
module tb_ptp;

   localparam int         D   = 100;
   localparam logic [6:0] DEV = 7'b001_000_0;

   logic        clk = 1'b0;
   logic        reset;
   logic        poweron, iob_reset;
   logic        datao_clear, datao_set, cono_clear, cono_set;
   logic        fm_datai, fm_status;
   logic [3:9]  ios;
   logic [0:35] iob_in;
   logic [1:7]  pi_req;
   logic [0:35] iob_out;
   logic        key_feed;
   logic        s_read;
   logic [31:0] s_readdata;
   logic        fe_data_rq;

   int checks   = 0;
   int failures = 0;
   int reads    = 0;
   logic [31:0] exp_q[$];

   ptp #(.DEV_CODE(DEV), .PUNCH_DELAY(D)) dut (
      .clk                 (clk),
      .reset               (reset),
      .iobus_iob_poweron   (poweron),
      .iobus_iob_reset     (iob_reset),
      .iobus_datao_clear   (datao_clear),
      .iobus_datao_set     (datao_set),
      .iobus_cono_clear    (cono_clear),
      .iobus_cono_set      (cono_set),
      .iobus_iob_fm_datai  (fm_datai),
      .iobus_iob_fm_status (fm_status),
      .iobus_ios           (ios),
      .iobus_iob_in        (iob_in),
      .iobus_pi_req        (pi_req),
      .iobus_iob_out       (iob_out),
      .key_tape_feed       (key_feed),
      .s_read              (s_read),
      .s_readdata          (s_readdata),
      .fe_data_rq          (fe_data_rq)
   );

   always #5 clk = ~clk;

   // Monitor: one line per front-end read transaction.
   always @(negedge clk) begin
      if (s_read) begin
         logic [31:0] e;
         reads++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL read#%0d: readdata=%h with no expected value queued", reads, s_readdata);
         end else begin
            e = exp_q.pop_front();
            if (s_readdata !== e) begin
               failures++;
               $display("FAIL read#%0d: readdata=%h required=%h", reads, s_readdata, e);
            end else begin
               $display("read#%0d readdata=%h ok", reads, s_readdata);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // which: 0 datao clear, 1 datao set, 2 cono clear, 3 cono set
   task automatic pulse(input int which, input logic [0:35] data);
      iob_in = data;
      case (which)
         0: datao_clear = 1'b1;
         1: datao_set   = 1'b1;
         2: cono_clear  = 1'b1;
         default: cono_set = 1'b1;
      endcase
      tick();
      datao_clear = 1'b0;
      datao_set   = 1'b0;
      cono_clear  = 1'b0;
      cono_set    = 1'b0;
      tick();
   endtask

   task automatic do_read(input logic [31:0] exp);
      exp_q.push_back(exp);
      s_read = 1'b1;
      tick();
      s_read = 1'b0;
   endtask

   task automatic chk(input string name, input logic [0:35] exp_out,
                      input logic [1:7] exp_pi, input logic exp_rq);
      fm_status = 1'b1;
      #1;
      checks++;
      if (iob_out !== exp_out) begin
         failures++;
         $display("FAIL %s coni: got %o required %o", name, iob_out, exp_out);
      end
      checks++;
      if (pi_req !== exp_pi) begin
         failures++;
         $display("FAIL %s pi_req: got %b required %b", name, pi_req, exp_pi);
      end
      checks++;
      if (fe_data_rq !== exp_rq) begin
         failures++;
         $display("FAIL %s fe_data_rq: got %b required %b", name, fe_data_rq, exp_rq);
      end
      $display("status %s coni=%o pi_req=%b fe_data_rq=%b", name, iob_out, pi_req, fe_data_rq);
      fm_status = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; poweron = 1'b1; iob_reset = 1'b0;
      datao_clear = 1'b0; datao_set = 1'b0; cono_clear = 1'b0; cono_set = 1'b0;
      fm_datai = 1'b0; fm_status = 1'b0; ios = DEV; iob_in = '0;
      key_feed = 1'b0; s_read = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      tick();

      // Reset state and an idle read
      chk("reset", 36'o0, 7'b0000000, 1'b0);
      do_read(32'h0);

      // Deselected CONO has no effect
      ios = 7'b001_000_1;
      pulse(3, 36'o17);
      ios = DEV;
      chk("desel", 36'o0, 7'b0000000, 1'b0);

      // Test 1: IO reset clears flag and PIA
      pulse(3, 36'o17);
      chk("cono17", 36'o17, 7'b0000001, 1'b0);
      iob_reset = 1'b1;
      tick();
      iob_reset = 1'b0;
      chk("iob_reset", 36'o0, 7'b0000000, 1'b0);

      // Test 2: PIA 3, frame 0o277
      pulse(3, 36'o3);
      pulse(1, 36'o277);
      chk("t2_req", 36'o23, 7'b0000000, 1'b1);
      do_read(32'h1BF);
      do_read(32'h0);                       // read outside REQ
      repeat (D - 1) tick();
      chk("t2_done", 36'o23, 7'b0000000, 1'b0);
      tick();
      chk("t2_flag", 36'o13, 7'b0010000, 1'b0);

      // Test 3: binary mode, PIA 1, buffer 0o77
      pulse(2, 36'o0);
      pulse(0, 36'o0);
      pulse(3, 36'o41);
      chk("t3_cono", 36'o41, 7'b0000000, 1'b0);
      pulse(1, 36'o77);
      do_read(32'h1BF);
      repeat (D + 1) tick();
      chk("t3_flag", 36'o51, 7'b1000000, 1'b0);

      // Test 4: DATAO clear in WAIT, CONO clear in the DONE clock
      pulse(2, 36'o0);
      pulse(0, 36'o0);
      pulse(3, 36'o2);
      pulse(1, 36'o5);
      do_read(32'h105);
      pulse(0, 36'o0);
      repeat (D - 2) tick();
      chk("t4_done", 36'o22, 7'b0000000, 1'b0);
      cono_clear = 1'b1;
      tick();
      cono_clear = 1'b0;
      chk("t4_clr", 36'o0, 7'b0000000, 1'b0);

      // Test 5: tape feed, three blank frames, no flag
      tick();
      pulse(3, 36'o4);
      key_feed = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t5_req", 36'o4, 7'b0000000, 1'b1);
         do_read(32'h100);
         repeat (D + 1) tick();
      end
      key_feed = 1'b0;
      tick();
      chk("t5_end", 36'o4, 7'b0000000, 1'b0);

      // Test 6: reset while in REQ drops the request at once
      pulse(1, 36'o1);
      chk("t6_req", 36'o24, 7'b0000000, 1'b1);
      reset = 1'b1;
      #1;
      checks++;
      if (fe_data_rq !== 1'b0) begin
         failures++;
         $display("FAIL t6_rst fe_data_rq: got %b required 0", fe_data_rq);
      end
      do_read(32'h0);
      reset = 1'b0;
      tick();
      chk("t6_after", 36'o0, 7'b0000000, 1'b0);

      tick();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard: %0d expected reads never seen, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
